alu_slice_sequencer: RTL and testbench
======================================

Name: alu_slice_sequencer

Overview:
- Shares one 5-bit combinational ALU (S[1:0], X, Y, Cin -> F, Cout) between two requesters.
- Executes each granted operation on operands SLICES times wider than the ALU, feeding the ALU one slice per cycle, LSB slice first.
- Chains the carry between slices for the add-with-carry op.
- Sits between requester logic and the ALU instance; the ALU stays outside and is driven through the alu_* ports.

Parameters:
- SLICE_W, 5, ALU datapath width in bits.
- SLICES, 2, number of slices per operation; operand width is OPW = SLICE_W*SLICES.
- CHAIN_OP, 2'b11, the op code whose slice carry-out is forwarded to the next slice's Cin.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  request valid, one bit per requester (bit0 = requester 0).
- req_ready  out  2  one-hot grant pulse; a request is accepted when req_valid[i] & req_ready[i].
- req_op  in  2x2  per-requester op code (S value).
- req_a  in  2xOPW  per-requester operand X.
- req_b  in  2xOPW  per-requester operand Y.
- req_cin  in  2  per-requester carry-in, applied to slice 0.
- alu_s  out  2  ALU select.
- alu_x  out  SLICE_W  ALU operand X slice.
- alu_y  out  SLICE_W  ALU operand Y slice.
- alu_cin  out  1  ALU carry-in.
- alu_f  in  SLICE_W  ALU result.
- alu_cout  in  1  ALU carry-out.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  1  index of the requester that owns the result.
- rsp_data  out  OPW  assembled result.
- rsp_cout  out  1  carry-out of the last slice.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE; all outputs 0, including alu_* and the response fields.
  - rr_last = 1, so requester 0 has priority first.
  - Asserting rst mid-operation aborts the operation; it is not replayed.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant round-robin among asserted req_valid, starting from the requester after rr_last.
  - req_ready is a combinational one-hot, asserted only in IDLE.
  - On grant:
    - latch op, a, b, cin, id;
    - set rr_last = id;
    - clear the slice counter k = 0;
    - go to EXEC.
  - No valid request -> stay in IDLE.
- EXEC, one slice per cycle:
  - alu_s = op_q.
  - alu_x = a_q[k*SLICE_W +: SLICE_W].
  - alu_y = b_q[k*SLICE_W +: SLICE_W].
  - alu_cin:
    - k == 0: cin_q;
    - else if op_q == CHAIN_OP: carry_q, the registered alu_cout from slice k-1;
    - else: cin_q.
  - At the clock edge:
    - res_q[k slice] <= alu_f;
    - carry_q <= alu_cout;
    - k <= k+1.
  - When k == SLICES-1, go to RESP instead of incrementing.
- alu_* outputs are driven only in EXEC; they are 0 in IDLE and RESP.
- RESP:
  - rsp_valid = 1; rsp_data = res_q; rsp_cout = carry_q from the last slice; rsp_id = id_q.
  - All rsp fields hold stable while rsp_valid=1 and rsp_ready=0.
  - rsp_valid & rsp_ready -> IDLE. A new grant can occur no earlier than the following cycle.
- Latency: grant edge -> rsp_valid asserted after SLICES+1 cycles.
  - Throughput is one operation per SLICES+2 cycles when rsp_ready is tied high.
- Both requesters valid in IDLE: strict alternation.
- A requester that drops req_valid before being granted loses nothing; no state is kept for it.
- req_* inputs are sampled only on the grant cycle; changes during EXEC/RESP are ignored.
- Arithmetic:
  - The wide result is the concatenation of slice results.
  - Overflow beyond OPW is reported only via rsp_cout.
  - Non-chained ops: rsp_cout = Cout of the last slice.

Decomposition:
- Shared package holds:
  - state enum {IDLE, EXEC, RESP};
  - SLICE_W default;
  - CHAIN_OP;
  - op code constants OP_00..OP_11, named by the team's ALU function names.
- Natural sub-module: rr_arbiter2, a two-way round-robin grant with rr_last state, instantiated once.
- Slice counter and FSM stay in the top module.

Test Plan:
- Chained add:
  - Stimulus: req0 with op=11, a=10'h01F, b=10'h001, cin=0; behavioural ALU model (op 11 = X+Y+Cin).
  - Required: slice0 F=00000, Cout=1; slice1 alu_cin=1; rsp_data=10'h020, rsp_cout=0, rsp_id=0; rsp_valid exactly 3 cycles after grant.
- Full-width overflow:
  - Stimulus: op=11, a=10'h3FF, b=10'h001, cin=0.
  - Required: rsp_data=0, rsp_cout=1.
- Non-chained op:
  - Stimulus: op=00, a=10'h01F, b=10'h001, cin=0.
  - Required: slice1 alu_cin=0, independent of the slice0 Cout.
- Arbitration:
  - Stimulus: both req_valid held high for 4 operations.
  - Required: grants alternate 0,1,0,1; rsp_id follows the same sequence.
- Backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles in RESP.
  - Required: rsp_data, rsp_id and rsp_cout stable; req_ready=0 throughout; IDLE one cycle after rsp_ready=1.
- Reset mid-EXEC:
  - Stimulus: assert rst while k=1.
  - Required: outputs 0 immediately (async, no clock edge needed); after release, the first grant goes to requester 0.

Source files
------------

// File: rtl/alu_slice_sequencer_pkg.sv
// alu_slice_sequencer_pkg: shared state encoding, op codes and defaults for the slice sequencer
package alu_slice_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam int SLICE_W_DEF = 5;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADC = 2'b11;
  localparam logic [1:0] CHAIN_OP_DEF = OP_ADC;
endpackage

// File: rtl/alu_slice_sequencer_arb.sv
// rr_arbiter2: two-way round-robin grant, priority goes to the requester after rr_last
module rr_arbiter2
  import alu_slice_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);
  logic rr_last;
  // one-hot grant, only when enabled
  always_comb grant = en ? {valid[1] & (~rr_last | ~valid[0]), valid[0] & (rr_last | ~valid[1])} : 2'b00;
  // remember the last winner; reset favours requester 0 first
  always_ff @(posedge clk or posedge rst)
    if (rst) rr_last <= 1'b1;
    else if (|grant) rr_last <= grant[1];
endmodule

// File: rtl/alu_slice_sequencer.sv
// alu_slice_sequencer: runs wide ops from two requesters through one narrow external ALU, slice by slice
module alu_slice_sequencer
  import alu_slice_sequencer_pkg::*;
#(
  parameter int SLICE_W = SLICE_W_DEF,
  parameter int SLICES = 2,
  parameter logic [1:0] CHAIN_OP = CHAIN_OP_DEF,
  localparam int OPW = SLICE_W * SLICES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [3:0]         req_op,
  input  logic [2*OPW-1:0]   req_a,
  input  logic [2*OPW-1:0]   req_b,
  input  logic [1:0]         req_cin,
  output logic [1:0]         alu_s,
  output logic [SLICE_W-1:0] alu_x,
  output logic [SLICE_W-1:0] alu_y,
  output logic               alu_cin,
  input  logic [SLICE_W-1:0] alu_f,
  input  logic               alu_cout,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [OPW-1:0]     rsp_data,
  output logic               rsp_cout
);
  localparam int KW = SLICES > 1 ? $clog2(SLICES) : 1;
  localparam logic [KW-1:0] KLAST = KW'(SLICES - 1);
  state_t state, state_n;
  logic [KW-1:0] k;
  logic [1:0] grant, op_q;
  logic [OPW-1:0] a_q, b_q, res_q;
  logic cin_q, carry_q, id_q, exec;
  rr_arbiter2 u_arb (.clk(clk), .rst(rst), .en(state == IDLE && !rst), .valid(req_valid), .grant(grant));
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state and outputs; ALU port is only driven while a slice is in flight
  always_comb begin
    state_n = (state == IDLE && |grant) ? EXEC :
              (state == EXEC && k == KLAST) ? RESP :
              (state == RESP && rsp_ready) ? IDLE : state;
    exec = state == EXEC;
    req_ready = grant;
    alu_s = exec ? op_q : 2'b00;
    alu_x = exec ? a_q[int'(k)*SLICE_W +: SLICE_W] : '0;
    alu_y = exec ? b_q[int'(k)*SLICE_W +: SLICE_W] : '0;
    alu_cin = exec & ((k != '0 && op_q == CHAIN_OP) ? carry_q : cin_q);
    rsp_valid = state == RESP;
    rsp_data = rsp_valid ? res_q : '0;
    rsp_cout = rsp_valid & carry_q;
    rsp_id = rsp_valid & id_q;
  end
  // latch the winning request, then collect one slice result and carry per cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      k <= '0;
      op_q <= 2'b00;
      a_q <= '0;
      b_q <= '0;
      cin_q <= 1'b0;
      id_q <= 1'b0;
      res_q <= '0;
      carry_q <= 1'b0;
    end else if (state == IDLE && |grant) begin
      k <= '0;
      op_q <= grant[1] ? req_op[3:2] : req_op[1:0];
      a_q <= grant[1] ? req_a[2*OPW-1:OPW] : req_a[OPW-1:0];
      b_q <= grant[1] ? req_b[2*OPW-1:OPW] : req_b[OPW-1:0];
      cin_q <= grant[1] ? req_cin[1] : req_cin[0];
      id_q <= grant[1];
    end else if (exec) begin
      res_q[int'(k)*SLICE_W +: SLICE_W] <= alu_f;
      carry_q <= alu_cout;
      if (k != KLAST) k <= k + 1'b1;
    end
endmodule

// File: tb/tb_alu_slice_sequencer.sv
// tb_alu_slice_sequencer: directed vectors plus hand-written sequences against a behavioural ALU
module tb_alu_slice_sequencer;
  logic clk = 0, rst = 1;
  logic [1:0] req_valid = 0, req_ready, req_cin = 0, alu_s;
  logic [3:0] req_op = 0;
  logic [19:0] req_a = 0, req_b = 0;
  logic [4:0] alu_x, alu_y, alu_f;
  logic alu_cin, alu_cout, rsp_valid, rsp_ready = 1, rsp_id, rsp_cout;
  logic [9:0] rsp_data;
  logic [5:0] sum;
  int checks = 0, errors = 0;

  alu_slice_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .alu_s(alu_s), .alu_x(alu_x),
    .alu_y(alu_y), .alu_cin(alu_cin), .alu_f(alu_f), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_cout(rsp_cout)
  );

  always #5 clk = ~clk;

  // 00 add, 01 and, 10 xor, 11 add-with-carry
  always_comb begin
    sum = {1'b0, alu_x} + {1'b0, alu_y} + {5'b0, alu_cin};
    alu_f = (alu_s == 2'b01) ? (alu_x & alu_y) : (alu_s == 2'b10) ? (alu_x ^ alu_y) : sum[4:0];
    alu_cout = (alu_s == 2'b00 || alu_s == 2'b11) ? sum[5] : 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_grant(input int id);
    int n = 0;
    #1;
    while (!req_ready[id] && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("grant_timeout", 32'(n < 20), 32'd1);
  endtask

  task automatic do_op(input int id, input logic [1:0] op, input logic [9:0] a, input logic [9:0] b,
                       input logic cin, output logic [9:0] d, output logic co, output logic rid,
                       output int lat, output logic f0z, output logic co0, output logic c1);
    @(negedge clk);
    req_valid[id] = 1; req_op[id*2 +: 2] = op; req_a[id*10 +: 10] = a;
    req_b[id*10 +: 10] = b; req_cin[id] = cin;
    wait_grant(id);
    @(negedge clk);
    req_valid[id] = 0;
    lat = 1; f0z = 0; co0 = 0; c1 = 0;
    while (!rsp_valid && lat < 20) begin
      if (lat == 1) begin f0z = (alu_f == 0); co0 = alu_cout; end
      if (lat == 2) c1 = alu_cin;
      @(negedge clk); lat++;
    end
    d = rsp_data; co = rsp_cout; rid = rsp_id;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [9:0] a, b;
    logic cin;
    logic [9:0] d;
    logic co;
  } vec_t;
  vec_t tv[7];

  initial begin
    logic [9:0] d, d0;
    logic co, rid, f0z, co0, c1;
    int lat, ng, nr;
    int gseq[4], rseq[4];
    logic [9:0] rdat[4];
    tv[0] = '{2'b11, 10'h01F, 10'h001, 1'b0, 10'h020, 1'b0};
    tv[1] = '{2'b11, 10'h3FF, 10'h001, 1'b0, 10'h000, 1'b1};
    tv[2] = '{2'b00, 10'h01F, 10'h001, 1'b0, 10'h000, 1'b0};
    tv[3] = '{2'b01, 10'h3A5, 10'h0F0, 1'b0, 10'h0A0, 1'b0};
    tv[4] = '{2'b10, 10'h3A5, 10'h0F0, 1'b0, 10'h355, 1'b0};
    tv[5] = '{2'b11, 10'h155, 10'h0AA, 1'b1, 10'h200, 1'b0};
    tv[6] = '{2'b00, 10'h3FF, 10'h3FF, 1'b1, 10'h3FF, 1'b1};

    req_valid = 2'b11;
    #2;
    chk("reset_outputs", {req_ready, alu_s, alu_x, alu_y, alu_cin, rsp_valid, rsp_data, rsp_cout, rsp_id}, 0);
    @(negedge clk);
    req_valid = 0;
    rst = 0;

    for (int i = 0; i < 7; i++) begin
      do_op(0, tv[i].op, tv[i].a, tv[i].b, tv[i].cin, d, co, rid, lat, f0z, co0, c1);
      chk($sformatf("v%0d_data", i), 32'(d), 32'(tv[i].d));
      chk($sformatf("v%0d_cout", i), 32'(co), 32'(tv[i].co));
      chk($sformatf("v%0d_id", i), 32'(rid), 0);
      chk($sformatf("v%0d_latency", i), 32'(lat), 3);
      if (i == 0) begin
        chk("chain_slice0_f_zero", 32'(f0z), 1);
        chk("chain_slice0_cout", 32'(co0), 1);
        chk("chain_slice1_cin", 32'(c1), 1);
      end
      if (i == 2) begin
        chk("nochain_slice0_cout", 32'(co0), 1);
        chk("nochain_slice1_cin", 32'(c1), 0);
      end
    end

    // backpressure: result must hold while the consumer stalls, and requests inside EXEC/RESP are ignored
    @(negedge clk);
    rsp_ready = 0;
    req_valid = 2'b10; req_op[3:2] = 2'b11; req_a[19:10] = 10'h123; req_b[19:10] = 10'h045; req_cin[1] = 0;
    wait_grant(1);
    @(negedge clk);
    req_valid = 2'b01; req_a[19:10] = 10'h000;
    #1;
    chk("bp_ready_in_exec", 32'(req_ready), 0);
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(negedge clk); #1; lat++; end
    chk("bp_data", 32'(rsp_data), 32'h168);
    chk("bp_id", 32'(rsp_id), 1);
    chk("bp_cout", 32'(rsp_cout), 0);
    d0 = rsp_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk($sformatf("bp_hold%0d", i), {rsp_valid, rsp_id, rsp_cout, rsp_data, req_ready}, {1'b1, 1'b1, 1'b0, d0, 2'b00});
    end
    rsp_ready = 1;
    @(negedge clk); #1;
    chk("bp_back_idle", {rsp_valid, req_ready}, {1'b0, 2'b01});
    req_valid = 0;

    // reset in the middle of the second slice
    @(negedge clk);
    req_valid = 2'b01; req_op[1:0] = 2'b11; req_a[9:0] = 10'h3FF; req_b[9:0] = 10'h001; req_cin[0] = 0;
    wait_grant(0);
    @(negedge clk);
    req_valid = 0;
    @(negedge clk); #1;
    chk("rst_pre_slice1", {alu_s, alu_x, alu_cin}, {2'b11, 5'h1F, 1'b1});
    req_valid = 2'b11;
    req_op = 4'b1011; req_a = {10'h3FF, 10'h001}; req_b = {10'h0F0, 10'h002}; req_cin = 0;
    rst = 1;
    #1;
    chk("rst_async_outputs", {req_ready, alu_s, alu_x, alu_y, alu_cin, rsp_valid, rsp_data, rsp_cout, rsp_id}, 0);
    @(negedge clk);
    rst = 0;

    // arbitration: both requesters held valid, expect strict alternation starting at 0
    ng = 0; nr = 0;
    for (int i = 0; i < 4; i++) begin gseq[i] = 9; rseq[i] = 9; rdat[i] = 0; end
    #1;
    for (int c = 0; c < 60 && nr < 4; c++) begin
      if (req_ready != 0 && ng < 4) begin
        chk("arb_onehot", 32'($countones(req_ready)), 1);
        gseq[ng] = int'(req_ready[1]); ng++;
      end
      if (rsp_valid) begin
        rseq[nr] = int'(rsp_id); rdat[nr] = rsp_data; nr++;
      end
      @(negedge clk); #1;
    end
    req_valid = 0;
    chk("arb_rsp_count", 32'(nr), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("arb_grant%0d", i), 32'(gseq[i]), 32'(i % 2));
      chk($sformatf("arb_rspid%0d", i), 32'(rseq[i]), 32'(i % 2));
      chk($sformatf("arb_data%0d", i), 32'(rdat[i]), (i % 2) ? 32'h30F : 32'h003);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
